// File: rtl/mul_exec_stage.sv
// mul_exec_stage: 16x16 unsigned shift-add multiplier on the stall-buffer word stream.
// Latency: bitlen(B)+1 cycles accept->out_valid (B==0: 1) with EARLY_TERM=1; 17 cycles with EARLY_TERM=0.
// Backpressure: stall_req held while busy or holding a word; 1-entry skid absorbs one in-flight word, further words are dropped (sticky overflow_err).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             synchronous flush, beats stall/accept/capture
//   stall             global freeze of the stage
//   in_valid, in_data word input, [31:16]=A multiplicand, [15:0]=B multiplier
//   out_valid         one-cycle result strobe, out_data = A*B
//   stall_req         combinational upstream stall request
//   busy              state != IDLE
//   overflow_err      sticky: a word was dropped because the skid was full
//   op_count          delivered results, wraps silently
module mul_exec_stage #(
  parameter int COUNT_W    = 16,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic               stall_req,
  output logic               busy,
  output logic               overflow_err,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [31:0]        acc_q, acc_d;
  logic [3:0]         iter_q, iter_d;
  logic               skid_vld_q, skid_vld_d;
  logic [31:0]        skid_dat_q, skid_dat_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] src;
  logic        accept;
  logic        in_taken;
  logic        skid_free;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    iter_d     = iter_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;

    // Skid word is older than the live input, so it goes first.
    src       = skid_vld_q ? skid_dat_q : in_data;
    accept    = (state_q == IDLE) && !stall && !flush && (skid_vld_q || in_valid);
    in_taken  = accept && !skid_vld_q;
    // Skid slot is reusable in the same cycle its word is being accepted.
    skid_free = !skid_vld_q || accept;

    if (flush) begin
      state_d    = IDLE;
      a_d        = '0;
      b_d        = '0;
      acc_d      = '0;
      iter_d     = '0;
      skid_vld_d = 1'b0;
      skid_dat_d = '0;
      ovf_d      = 1'b0;
    end else begin
      if (accept && skid_vld_q) begin
        skid_vld_d = 1'b0;
      end
      // Skid capture runs even while stalled.
      if (in_valid && !in_taken) begin
        if (skid_free) begin
          skid_vld_d = 1'b1;
          skid_dat_d = in_data;
        end else begin
          ovf_d = 1'b1;
        end
      end

      if (!stall) begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              a_d    = {16'b0, src[31:16]};
              b_d    = src[15:0];
              acc_d  = '0;
              iter_d = '0;
              // Fixed-latency mode always walks all 16 bits, even for B==0.
              if ((src[15:0] == 16'd0) && (EARLY_TERM != 1'b0)) begin
                state_d = DONE;
              end else begin
                state_d = CALC;
              end
            end
          end
          CALC: begin
            if (b_q[0]) begin
              acc_d = acc_q + a_q;
            end
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            iter_d = iter_q + 4'd1;
            if (EARLY_TERM != 1'b0) begin
              if (b_q[15:1] == 15'd0) begin
                state_d = DONE;
              end
            end else if (iter_q == 4'd15) begin
              state_d = DONE;
            end
          end
          DONE: begin
            cnt_d   = cnt_q + COUNT_W'(1);
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      iter_q     <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      iter_q     <= iter_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == DONE) && !stall && !flush;
  // Accumulator is a register and is held after DONE, so it doubles as the output.
  assign out_data     = acc_q;
  assign stall_req    = busy || skid_vld_q || in_valid;
  assign overflow_err = ovf_q;
  assign op_count     = cnt_q;

endmodule

// File: tb/tb_mul_exec_stage.sv
module tb_mul_exec_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic [31:0] in_data;

  logic        ov0, sr0, bz0, of0;
  logic [31:0] od0;
  logic [15:0] oc0;
  logic        ov1, sr1, bz1, of1;
  logic [31:0] od1;
  logic [15:0] oc1;
  logic        ov2, sr2, bz2, of2;
  logic [31:0] od2;
  logic [3:0]  oc2;

  int n_vec;
  int n_err;
  int exp_cnt;
  int sel;

  logic        ov, sr, bz, of;
  logic [31:0] od, oc;

  mul_exec_stage #(.COUNT_W(16), .EARLY_TERM(1'b1)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov0), .out_data(od0), .stall_req(sr0), .busy(bz0),
    .overflow_err(of0), .op_count(oc0)
  );

  mul_exec_stage #(.COUNT_W(16), .EARLY_TERM(1'b0)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_data(od1), .stall_req(sr1), .busy(bz1),
    .overflow_err(of1), .op_count(oc1)
  );

  mul_exec_stage #(.COUNT_W(4), .EARLY_TERM(1'b1)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov2), .out_data(od2), .stall_req(sr2), .busy(bz2),
    .overflow_err(of2), .op_count(oc2)
  );

  always_comb begin
    ov = ov0; od = od0; sr = sr0; bz = bz0; of = of0; oc = {16'b0, oc0};
    if (sel == 1) begin
      ov = ov1; od = od1; sr = sr1; bz = bz1; of = of1; oc = {16'b0, oc1};
    end else if (sel == 2) begin
      ov = ov2; od = od2; sr = sr2; bz = bz2; of = of2; oc = {28'b0, oc2};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    #1;
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
  endtask

  // Apply one word for one cycle, wait (bounded) for its result.
  task automatic run_op(input string tag, input logic [31:0] w, input int exp_lat,
                        input logic [31:0] exp_res);
    int lat;
    tick();
    in_valid = 1'b1;
    in_data  = w;
    #1;
    lat = 0;
    tick();
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!ov && lat < 40) begin
      tick();
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, od, exp_res);
    exp_cnt++;
    tick();
    #1;
    chk({tag, "_ov_once"}, ov, 0);
    chk({tag, "_cnt"}, oc, (sel == 2) ? (exp_cnt % 16) : exp_cnt);
  endtask

  initial begin
    int lat;
    int seen;
    n_vec    = 0;
    n_err    = 0;
    exp_cnt  = 0;
    sel      = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    tick();
    tick();
    chk("rst_ov", ov, 0);
    chk("rst_od", od, 0);
    chk("rst_sr", sr, 0);
    chk("rst_busy", bz, 0);
    chk("rst_ovf", of, 0);
    chk("rst_cnt", oc, 0);
    reset = 1'b0;

    // 3*5: accept cycle 0, out_valid only in cycle 4, stall_req high 0..4
    tick();
    in_valid = 1'b1;
    in_data  = 32'h0003_0005;
    #1;
    chk("t1_sr_c0", sr, 1);
    chk("t1_busy_c0", bz, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      in_valid = 1'b0;
      #1;
      chk("t1_ov", ov, (c == 4) ? 1 : 0);
      chk("t1_sr", sr, 1);
    end
    chk("t1_od", od, 32'h0000_000F);
    exp_cnt = 1;
    tick();
    #1;
    chk("t1_cnt", oc, 1);
    chk("t1_ov_off", ov, 0);
    chk("t1_sr_off", sr, 0);

    run_op("ffff", 32'hFFFF_FFFF, 17, 32'hFFFE_0001);
    run_op("bzero", 32'h1234_0000, 1, 32'h0);
    run_op("bmsb", 32'h8000_8000, 17, 32'h4000_0000);

    // Back-to-back W1, W2 (to skid), W3 (dropped)
    do_reset();
    tick();
    in_valid = 1'b1;
    in_data  = 32'h0002_0003;
    #1;
    tick();
    in_data = 32'h0004_0004;
    #1;
    chk("b2b_busy_c1", bz, 1);
    chk("b2b_ovf_c1", of, 0);
    tick();
    in_data = 32'h0001_0001;
    #1;
    chk("b2b_ovf_c2", of, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b_ovf_c3", of, 1);
    chk("b2b_ov_c3", ov, 1);
    chk("b2b_od_c3", od, 32'h6);
    tick();
    #1;
    chk("b2b_busy_c4", bz, 0);
    chk("b2b_sr_c4", sr, 1);
    chk("b2b_ov_c4", ov, 0);
    for (int c = 5; c <= 8; c++) begin
      tick();
      #1;
      chk("b2b_ov_w2", ov, (c == 8) ? 1 : 0);
    end
    chk("b2b_od_w2", od, 32'h10);
    exp_cnt = 2;
    tick();
    #1;
    chk("b2b_cnt", oc, 2);
    chk("b2b_idle", bz, 0);
    chk("b2b_sr_idle", sr, 0);
    chk("b2b_ovf_sticky", of, 1);

    // Flush in cycle 3 of a long op, with a word arriving the same cycle
    tick();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    tick();
    #1;
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0002_0002;
    #1;
    chk("fl_ov_c3", ov, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_busy", bz, 0);
    chk("fl_sr_skid_empty", sr, 0);
    chk("fl_ovf", of, 0);
    chk("fl_od", od, 0);
    chk("fl_cnt", oc, exp_cnt);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      if (ov) seen++;
    end
    chk("fl_no_result", seen, 0);

    // Stall 5 cycles mid-CALC on 0xFF*0xFF: latency 9 -> 14
    tick();
    in_valid = 1'b1;
    in_data  = 32'h00FF_00FF;
    #1;
    lat = 0;
    tick();
    in_valid = 1'b0;
    #1;
    lat++;
    tick();
    #1;
    lat++;
    for (int i = 0; i < 5; i++) begin
      tick();
      stall = 1'b1;
      #1;
      lat++;
      chk("st_ov_frozen", ov, 0);
      chk("st_busy", bz, 1);
    end
    tick();
    stall = 1'b0;
    #1;
    lat++;
    while (!ov && lat < 60) begin
      tick();
      #1;
      lat++;
    end
    chk("st_lat", lat, 14);
    chk("st_od", od, 32'h0000_FE01);
    exp_cnt++;
    tick();
    #1;
    chk("st_ov_once", ov, 0);
    chk("st_cnt", oc, exp_cnt);

    // Stall across DONE: cycles 4..6 stalled, pulse in cycle 7
    tick();
    in_valid = 1'b1;
    in_data  = 32'h0003_0005;
    #1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      in_valid = 1'b0;
      #1;
    end
    for (int c = 4; c <= 6; c++) begin
      tick();
      stall = 1'b1;
      #1;
      chk("sd_ov_stalled", ov, 0);
      chk("sd_busy", bz, 1);
    end
    chk("sd_cnt_frozen", oc, exp_cnt);
    tick();
    stall = 1'b0;
    #1;
    chk("sd_ov", ov, 1);
    chk("sd_od", od, 32'hF);
    exp_cnt++;
    tick();
    #1;
    chk("sd_ov_once", ov, 0);
    chk("sd_cnt", oc, exp_cnt);
    chk("sd_idle", bz, 0);

    // Reset mid-CALC clears everything immediately, including op_count
    tick();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    tick();
    #1;
    tick();
    reset = 1'b1;
    #1;
    chk("mr_ov", ov, 0);
    chk("mr_od", od, 0);
    chk("mr_busy", bz, 0);
    chk("mr_sr", sr, 0);
    chk("mr_ovf", of, 0);
    chk("mr_cnt", oc, 0);
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
    run_op("post_rst", 32'h0007_0009, 5, 32'h0000_003F);

    // Fixed 16-iteration instance
    do_reset();
    sel = 1;
    run_op("et0_3x5", 32'h0003_0005, 17, 32'h0000_000F);
    run_op("et0_ffff", 32'hFFFF_FFFF, 17, 32'hFFFE_0001);

    // 4-bit counter wraps 15 -> 0
    do_reset();
    sel = 2;
    for (int i = 0; i < 16; i++) begin
      run_op("wrap", 32'h1234_0000, 1, 32'h0);
    end
    chk("wrap_zero", oc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
